// File: rtl/i2c_init_pkg.sv
// rtl/i2c_init_pkg.sv - shared state encoding and quarter-phase constants for i2c_init_seq
package i2c_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_FINISH,
        ST_FAIL
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-bit tick divider, held at zero while CLR is high
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign TICK = !CLR && (r_cnt == LAST);

endmodule

// File: rtl/i2c_init_seq.sv
// rtl/i2c_init_seq.sv - I2C register-init sequencer; NACK retry enabled by I2C_INIT_RETRY_EN
module i2c_init_seq
    import i2c_init_pkg::*;
#(
    parameter int         N_ENTRIES = 16,
    parameter logic [6:0] DEV_ADDR  = 7'h76,
    parameter int         CLK_DIV   = 125,
    parameter int         GAP_CYC   = 64,
    localparam int        AW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    output logic [AW-1:0] TBL_ADDR,
    input  logic [15:0]   TBL_DATA,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW-1:0] ERR_IDX,
    output logic          SCL,
    inout  wire           SDA
);

    localparam logic [31:0]   GAP_LAST = (GAP_CYC > 0) ? 32'(GAP_CYC - 1) : 32'd0;
    localparam logic [AW-1:0] IDX_LAST = AW'(N_ENTRIES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [7:0]    r_shift;
    logic [15:0]   r_tbl;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_err_idx;
    logic          r_fcnt;
    logic [31:0]   r_gap_cnt;
    logic          r_nack;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_scl;
    logic          r_sda_low;

    logic w_tick;
    logic w_tick_clr;
    logic w_qend;
    logic w_gap_done;
    logic w_retry;
    logic w_scl;
    logic w_sda_low;

`ifdef I2C_INIT_RETRY_EN
    logic [1:0] r_retry;
    assign w_retry = r_nack && (r_retry != 2'd3);
`else
    assign w_retry = 1'b0;
`endif

    // Divider only runs while a bit-level state is on the wire.
    assign w_tick_clr = !((r_state == ST_START) || (r_state == ST_BYTE) ||
                          (r_state == ST_ACK)   || (r_state == ST_STOP));

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (w_tick_clr),
        .TICK  (w_tick)
    );

    assign w_qend     = w_tick && (r_q == Q3);
    assign w_gap_done = (r_gap_cnt >= GAP_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START && !r_done && !r_err) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (r_fcnt) w_next = ST_START;
            end
            ST_START: begin
                w_scl     = (r_q != Q3);
                w_sda_low = (r_q != Q0);
                if (w_qend) w_next = ST_BYTE;
            end
            ST_BYTE: begin
                w_scl     = (r_q == Q1) || (r_q == Q2);
                w_sda_low = !r_shift[7];
                if (w_qend && (r_bit == 3'd7)) w_next = ST_ACK;
            end
            ST_ACK: begin
                w_scl = (r_q == Q1) || (r_q == Q2);
                if (w_qend) w_next = (r_nack || (r_byte == 2'd2)) ? ST_STOP : ST_BYTE;
            end
            ST_STOP: begin
                w_scl     = (r_q != Q0);
                w_sda_low = (r_q == Q0) || (r_q == Q1);
                if (w_qend) w_next = (r_nack && !w_retry) ? ST_FAIL : ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_done) w_next = (!w_retry && (r_idx == IDX_LAST)) ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: w_next = ST_FINISH;
            ST_FAIL:   w_next = ST_FAIL;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_q       <= Q0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_shift   <= 8'd0;
            r_tbl     <= 16'd0;
            r_idx     <= '0;
            r_err_idx <= '0;
            r_fcnt    <= 1'b0;
            r_gap_cnt <= 32'd0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
            r_retry   <= 2'd0;
`endif
        end else begin
            // Pins are registered so SCL/SDA never glitch on decode.
            r_scl     <= w_scl;
            r_sda_low <= w_sda_low;
            if (w_tick) r_q <= r_q + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_FETCH) begin
                        r_busy <= 1'b1;
                        r_idx  <= '0;
                        r_fcnt <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
                        r_retry <= 2'd0;
`endif
                    end
                end
                ST_FETCH: begin
                    r_fcnt <= !r_fcnt;
                    if (r_fcnt) begin
                        r_tbl   <= TBL_DATA;
                        r_shift <= {DEV_ADDR, 1'b0};
                        r_byte  <= 2'd0;
                        r_bit   <= 3'd0;
                    end
                end
                ST_BYTE: begin
                    if (w_qend) begin
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                end
                ST_ACK: begin
                    if (w_tick && (r_q == Q2)) r_nack <= SDA;
                    if (w_qend && !r_nack) begin
                        r_byte  <= r_byte + 1'b1;
                        r_shift <= (r_byte == 2'd0) ? r_tbl[15:8] : r_tbl[7:0];
                    end
                end
                ST_STOP: begin
                    if (w_qend) begin
                        r_gap_cnt <= 32'd0;
                        if (w_next == ST_FAIL) r_err_idx <= r_idx;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 32'd1;
                    if (w_next == ST_FETCH) begin
                        r_fcnt <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
                        if (w_retry) begin
                            r_retry <= r_retry + 1'b1;
                        end else begin
                            r_retry <= 2'd0;
                            r_idx   <= r_idx + 1'b1;
                        end
`else
                        r_idx <= r_idx + 1'b1;
`endif
                    end
                end
                ST_FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                ST_FAIL: begin
                    r_err  <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign TBL_ADDR = r_idx;
    assign ERR_IDX  = r_err_idx;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign SCL      = r_scl;
    assign SDA      = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_init_seq.md
I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16, number of register-write entries in the init table (1..256).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h76, 7-bit I2C slave address used for every write.
REQ-003 SHALL have parameter CLK_DIV, default 125, CLK cycles per quarter SCL bit period (>=2).
REQ-004 SHALL have parameter GAP_CYC, default 64, idle CLK cycles between STOP and the next START.
REQ-005 SHALL have port CLK input 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port RST_N input 1, reset: synchronous, active-low.
REQ-007 SHALL have port START input 1, level-sampled request to run the whole table.
REQ-008 SHALL have port TBL_ADDR output $clog2(N_ENTRIES), index of the entry being fetched.
REQ-009 SHALL have port TBL_DATA input 16, {reg[15:8], value[7:0]}, valid exactly 1 cycle after TBL_ADDR changes.
REQ-010 SHALL have port BUSY output 1, high from START acceptance until DONE or ERR.
REQ-011 SHALL have port DONE output 1, sticky; all entries written with ACK.
REQ-012 SHALL have port ERR output 1, sticky; a NACK ended the sequence.
REQ-013 SHALL have port ERR_IDX output $clog2(N_ENTRIES), entry index on which ERR occurred.
REQ-014 SHALL have port SCL output 1, push-pull I2C clock.
REQ-015 SHALL have port SDA inout 1, open-drain; driven 0 or released to Z only, never driven 1.

Function
REQ-016 SHALL implement states IDLE, FETCH, START, BYTE, ACK, STOP, GAP, FINISH, FAIL.
REQ-017 SHALL leave IDLE only when START=1 with DONE=0 and ERR=0; BUSY rises the next cycle; START while BUSY is ignored.
REQ-018 SHALL derive a quarter-tick every CLK_DIV cycles; the divider counter SHALL reload to 0 on each state entry from IDLE/GAP.
REQ-019 SHALL transmit each bit as 4 quarter-ticks: q0 SCL=0 and SDA updated, q1 SCL=1, q2 SCL=1 with SDA sampled at q2 end, q3 SCL=0.
REQ-020 SHALL generate START as SDA falling while SCL=1, and STOP as SDA rising while SCL=1, each spanning 4 quarter-ticks.
REQ-021 SHALL send per entry, MSB first: {DEV_ADDR,1'b0}, reg byte, value byte, each followed by one ACK bit with SDA released.
REQ-022 SHALL treat a sampled SDA=1 in ACK as NACK, branch to STOP then FAIL, and latch ERR_IDX with the current index.
REQ-023 SHALL, after STOP, wait GAP_CYC cycles in GAP, then FETCH index+1, or FINISH when index = N_ENTRIES-1 (no index wrap).
REQ-024 SHALL, in FINISH, set DONE=1 and BUSY=0; in FAIL, set ERR=1 and BUSY=0; both stay until reset.
REQ-025 SHALL hold SCL=1 and SDA released in IDLE, GAP, FINISH, FAIL.

Reset
REQ-026 SHALL on RST_N=0 at a CLK edge set state IDLE, SCL=1, SDA released, BUSY=0, DONE=0, ERR=0, TBL_ADDR=0, ERR_IDX=0, retry count 0.
REQ-027 SHALL on reset mid-transfer release the bus on the same edge without generating STOP.

Configuration
REQ-028 SHALL with macro I2C_INIT_RETRY_EN defined retry a NACKed entry up to 3 times (STOP, GAP, restart same index), entering FAIL only on the 4th NACK; retry count clears per entry.
REQ-029 SHALL without I2C_INIT_RETRY_EN enter FAIL on the first NACK and contain no retry counter.

Structure
REQ-030 SHALL place the state enumeration and the quarter-phase constants in shared package i2c_init_pkg.
REQ-031 SHALL implement the quarter-tick divider as sub-module i2c_tick_gen (parameter CLK_DIV, ports CLK, RST_N, CLR, TICK).

Verification
REQ-032 SHALL cover: CLK_DIV=4, N_ENTRIES=2, table {0x49C0,0x2109}, slave ACKs all -> SDA bytes 0xEC,0x49,0xC0,0xEC,0x21,0x09; DONE=1, ERR=0.
REQ-033 SHALL cover: slave NACKs value byte of entry 1 (retry off) -> STOP seen, ERR=1, ERR_IDX=1, DONE=0, no further START.
REQ-034 SHALL cover: I2C_INIT_RETRY_EN, entry 0 NACKed twice then ACKed -> 3 address phases on entry 0, DONE=1, ERR=0.
REQ-035 SHALL cover: RST_N=0 during reg byte of entry 0 -> next cycle SCL=1, SDA=Z, BUSY=0; new START reruns from index 0.
REQ-036 SHALL cover: START held high throughout and pulsed after DONE -> exactly one table pass; bit period = 16 CLK cycles at CLK_DIV=4.
